// File: rtl/bp_pkg.sv
// Shared types and default widths for the gshare predictor table controller.
//   ctrl_state_e : controller FSM states (table clear sweep, normal run, drain)
//   cnt_e        : 2-bit saturating direction counter encoding
//   btb_entry_t  : BTB entry layout {valid, tag, target[31:2]} at default widths
package bp_pkg;

    localparam int BTB_IDX_W_DEF = 10;
    localparam int PHT_IDX_W_DEF = 8;
    localparam int TAG_W_DEF     = 20;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_e;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } cnt_e;

    typedef struct packed {
        logic                 valid;
        logic [TAG_W_DEF-1:0] tag;
        logic [29:0]          target;
    } btb_entry_t;

endpackage

// File: rtl/bp_table_ctrl_if.sv
// Update / table-port bundle between the EX-stage resolver, the predictor
// tables and the table controller.
//   i_upd_*       : resolved branch update from EX
//   o_pht_raddr   : PHT async-read address, i_pht_rdata returns the counter
//   o_pht_w*      : PHT write port
//   o_btb_w*      : BTB write port, data = {valid, tag, target[31:2]}
// master = controller side, slave = environment (EX stage + tables).
interface bp_table_ctrl_if
    import bp_pkg::*;
#(
    parameter int BTB_IDX_W = BTB_IDX_W_DEF,
    parameter int PHT_IDX_W = PHT_IDX_W_DEF,
    parameter int TAG_W     = TAG_W_DEF
);
    logic                 i_upd_valid;
    logic [31:0]          i_upd_pc;
    logic                 i_upd_taken;
    logic [31:0]          i_upd_target;
    logic [PHT_IDX_W-1:0] i_upd_pattern;

    logic [PHT_IDX_W-1:0] o_pht_raddr;
    logic [1:0]           i_pht_rdata;

    logic                 o_pht_we;
    logic [PHT_IDX_W-1:0] o_pht_waddr;
    logic [1:0]           o_pht_wdata;

    logic                 o_btb_we;
    logic [BTB_IDX_W-1:0] o_btb_waddr;
    logic [TAG_W+30:0]    o_btb_wdata;

    modport master (
        input  i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target, i_upd_pattern,
        input  i_pht_rdata,
        output o_pht_raddr,
        output o_pht_we, o_pht_waddr, o_pht_wdata,
        output o_btb_we, o_btb_waddr, o_btb_wdata
    );

    modport slave (
        output i_upd_valid, i_upd_pc, i_upd_taken, i_upd_target, i_upd_pattern,
        output i_pht_rdata,
        input  o_pht_raddr,
        input  o_pht_we, o_pht_waddr, o_pht_wdata,
        input  o_btb_we, o_btb_waddr, o_btb_wdata
    );

endinterface

// File: rtl/bp_sat_cnt.sv
// Combinational 2-bit saturating counter step.
//   i_cnt   : current counter
//   i_taken : resolved direction
//   o_next  : taken -> min(ST, cnt+1), not taken -> max(SNT, cnt-1)
module bp_sat_cnt
    import bp_pkg::*;
(
    input  logic [1:0] i_cnt,
    input  logic       i_taken,
    output logic [1:0] o_next
);

    always_comb begin
        o_next = i_cnt;
        if (i_taken) begin
            if (i_cnt != ST) begin
                o_next = i_cnt + 2'd1;
            end
        end else if (i_cnt != SNT) begin
            o_next = i_cnt - 2'd1;
        end
    end

endmodule

// File: rtl/bp_table_ctrl.sv
// Single-writer controller for the gshare BTB/PHT tables.
//   i_clk, i_rst    : clock, synchronous active-high reset
//   i_flush_req     : request a full table clear
//   bus (master)    : EX update in, PHT read port, PHT and BTB write ports
//   o_ghr_clr       : pulse in the first cycle of every clear sweep
//   o_pred_en       : tables valid, predictor may predict taken
//   o_clr_done      : pulse in the cycle the last BTB entry is cleared
//   o_upd_dropped   : pulse when an update arrives outside RUN
// The clear sweep owns both write ports; otherwise the S2 stage of the
// PHT read-modify-write pipeline owns them.
module bp_table_ctrl
    import bp_pkg::*;
#(
    parameter int BTB_IDX_W = BTB_IDX_W_DEF,
    parameter int PHT_IDX_W = PHT_IDX_W_DEF,
    parameter int TAG_W     = TAG_W_DEF
)(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush_req,
    bp_table_ctrl_if.master  bus,
    output logic             o_ghr_clr,
    output logic             o_pred_en,
    output logic             o_clr_done,
    output logic             o_upd_dropped
);

    // One spare bit so the PHT range compare works when both tables are equal size.
    localparam int                 SWEEP_W    = BTB_IDX_W + 1;
    localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'((1 << BTB_IDX_W) - 1);
    localparam logic [SWEEP_W-1:0] PHT_DEPTH  = SWEEP_W'(1 << PHT_IDX_W);

    ctrl_state_e          state_reg, state_next;
    logic [SWEEP_W-1:0]   idx_reg, idx_next;

    logic                 s2_valid_reg;
    logic [PHT_IDX_W-1:0] s2_pattern_reg;
    logic                 s2_taken_reg;
    logic [1:0]           s2_cnt_reg;
    logic [BTB_IDX_W-1:0] s2_btb_idx_reg;
    logic [TAG_W-1:0]     s2_tag_reg;
    logic [29:0]          s2_target_reg;

    logic [1:0]           s2_next_cnt;
    logic [1:0]           s1_cnt;
    logic                 in_clear, in_run, sweep_last, upd_accept;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{bus.i_upd_pc[1:0], bus.i_upd_target[1:0]};

    bp_sat_cnt u_sat_cnt (
        .i_cnt   (s2_cnt_reg),
        .i_taken (s2_taken_reg),
        .o_next  (s2_next_cnt)
    );

    assign in_clear   = (state_reg == CLEAR);
    assign in_run     = (state_reg == RUN);
    assign sweep_last = in_clear && (idx_reg == SWEEP_LAST);
    // An update in the same cycle as an accepted flush would land in a table
    // about to be wiped, so it is dropped too.
    assign upd_accept = bus.i_upd_valid && in_run && !i_flush_req;

    assign o_upd_dropped = bus.i_upd_valid && !upd_accept;
    assign o_pred_en     = in_run;
    assign o_ghr_clr     = in_clear && (idx_reg == '0);
    assign o_clr_done    = sweep_last && !i_flush_req;

    assign bus.o_pht_raddr = in_run ? bus.i_upd_pattern : '0;

    // The table read is stale when S2 is writing the same entry this cycle.
    assign s1_cnt = (s2_valid_reg && (s2_pattern_reg == bus.i_upd_pattern))
                    ? s2_next_cnt : bus.i_pht_rdata;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        unique case (state_reg)
            CLEAR: begin
                if (i_flush_req) begin
                    idx_next = '0;
                end else if (sweep_last) begin
                    state_next = RUN;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + SWEEP_W'(1);
                end
            end
            RUN: begin
                if (i_flush_req) begin
                    state_next = s2_valid_reg ? DRAIN : CLEAR;
                    idx_next   = '0;
                end
            end
            DRAIN: begin
                state_next = CLEAR;
                idx_next   = '0;
            end
            default: begin
                state_next = CLEAR;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        bus.o_pht_we    = 1'b0;
        bus.o_pht_waddr = '0;
        bus.o_pht_wdata = '0;
        bus.o_btb_we    = 1'b0;
        bus.o_btb_waddr = '0;
        bus.o_btb_wdata = '0;
        if (in_clear) begin
            bus.o_btb_we    = 1'b1;
            bus.o_btb_waddr = idx_reg[BTB_IDX_W-1:0];
            bus.o_pht_we    = (idx_reg < PHT_DEPTH);
            bus.o_pht_waddr = idx_reg[PHT_IDX_W-1:0];
            bus.o_pht_wdata = SNT;
        end else if (s2_valid_reg) begin
            bus.o_pht_we    = 1'b1;
            bus.o_pht_waddr = s2_pattern_reg;
            bus.o_pht_wdata = s2_next_cnt;
            bus.o_btb_we    = s2_taken_reg;
            if (s2_taken_reg) begin
                bus.o_btb_waddr = s2_btb_idx_reg;
                bus.o_btb_wdata = {1'b1, s2_tag_reg, s2_target_reg};
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= CLEAR;
            idx_reg      <= '0;
            s2_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            s2_valid_reg <= upd_accept;
        end
    end

    // Payload needs no reset: it is only observed while s2_valid_reg is set.
    always_ff @(posedge i_clk) begin
        if (upd_accept) begin
            s2_pattern_reg <= bus.i_upd_pattern;
            s2_taken_reg   <= bus.i_upd_taken;
            s2_cnt_reg     <= s1_cnt;
            s2_btb_idx_reg <= bus.i_upd_pc[BTB_IDX_W+1:2];
            s2_tag_reg     <= bus.i_upd_pc[31:32-TAG_W];
            s2_target_reg  <= bus.i_upd_target[31:2];
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
module tb_bp_table_ctrl;
    localparam int BTB_IDX_W = 10;
    localparam int PHT_IDX_W = 8;
    localparam int TAG_W     = 20;
    localparam int BTB_N     = 1 << BTB_IDX_W;
    localparam int PHT_N     = 1 << PHT_IDX_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;
    logic ghr_clr, pred_en, clr_done, upd_dropped;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    bp_table_ctrl_if #(.BTB_IDX_W(BTB_IDX_W), .PHT_IDX_W(PHT_IDX_W), .TAG_W(TAG_W)) bus ();

    bp_table_ctrl #(.BTB_IDX_W(BTB_IDX_W), .PHT_IDX_W(PHT_IDX_W), .TAG_W(TAG_W)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_flush_req   (flush),
        .bus           (bus),
        .o_ghr_clr     (ghr_clr),
        .o_pred_en     (pred_en),
        .o_clr_done    (clr_done),
        .o_upd_dropped (upd_dropped)
    );

    // Environment PHT: async read, written by the controller's write port.
    logic [1:0] env_pht [PHT_N];
    logic       rd_force_en  = 1'b1;
    logic [1:0] rd_force_val = 2'd0;

    always_comb bus.i_pht_rdata = rd_force_en ? rd_force_val : env_pht[bus.o_pht_raddr];

    always_ff @(posedge clk) begin
        if (bus.o_pht_we) env_pht[bus.o_pht_waddr] <= bus.o_pht_wdata;
    end

    // Reference model: architectural counter value per pattern, plus the
    // write the table should see one cycle after an accepted update.
    int          truth [PHT_N];
    bit          pend_v = 1'b0;
    logic [7:0]  pend_p;
    logic [1:0]  pend_c;
    bit          pend_tk;
    logic [31:0] pend_pc, pend_tgt;
    int          upd_no = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int c, input bit tk);
        if (tk) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic drive(input bit v, input logic [7:0] p, input bit tk,
                         input logic [31:0] pc, input logic [31:0] tgt);
        bus.i_upd_valid   = v;
        bus.i_upd_pattern = p;
        bus.i_upd_taken   = tk;
        bus.i_upd_pc      = pc;
        bus.i_upd_target  = tgt;
    endtask

    task automatic check_pend();
        logic [TAG_W+30:0] exp_btb;
        if (pend_v) begin
            exp_btb = {1'b1, pend_pc[31:32-TAG_W], pend_tgt[31:2]};
            chk("pht_we", bus.o_pht_we, 1);
            chk("pht_waddr", bus.o_pht_waddr, pend_p);
            chk("pht_wdata", bus.o_pht_wdata, pend_c);
            chk("btb_we", bus.o_btb_we, pend_tk);
            if (pend_tk) begin
                chk("btb_waddr", bus.o_btb_waddr, pend_pc[BTB_IDX_W+1:2]);
                chk("btb_wdata", bus.o_btb_wdata, exp_btb);
            end
        end else begin
            chk("pht_we_idle", bus.o_pht_we, 0);
            chk("btb_we_idle", bus.o_btb_we, 0);
        end
    endtask

    // One RUN cycle. exp_cnt >= 0 overrides the model (forced-rdata cases).
    task automatic run_cycle(input bit v, input logic [7:0] p, input bit tk,
                             input logic [31:0] pc, input logic [31:0] tgt, input int exp_cnt);
        int c;
        drive(v, p, tk, pc, tgt);
        flush = 1'b0;
        #1;
        check_pend();
        chk("pred_en_run", pred_en, 1);
        chk("upd_dropped_run", upd_dropped, 0);
        if (v) begin
            chk("pht_raddr", bus.o_pht_raddr, p);
            if (exp_cnt >= 0) begin
                c = exp_cnt;
            end else begin
                truth[p] = sat(truth[p], tk);
                c = truth[p];
            end
            pend_v = 1'b1; pend_p = p; pend_c = 2'(c); pend_tk = tk; pend_pc = pc; pend_tgt = tgt;
            upd_no++;
            $display("upd %0d: pattern=0x%02h taken=%0d pc=0x%08h expect_cnt=%0d", upd_no, p, tk, pc, c);
        end else begin
            pend_v = 1'b0;
        end
        @(negedge clk);
    endtask

    // Called at the start of the first CLEAR cycle; follows the sweep to o_clr_done.
    task automatic sweep(input string tag, input int flush_at);
        int e = 0, cyc = 0, btb_n = 0, pht_n = 0, ghr_n = 0, done_n = 0, done_cyc = -1, bad = 0;
        int budget = BTB_N + 16 + ((flush_at > 0) ? flush_at : 0);
        int exp_btb, exp_pht, exp_ghr, exp_done;
        bit fin = 1'b0;
        bit v;
        while (!fin && cyc < budget) begin
            v = ($urandom_range(0, 3) == 0);
            drive(v, 8'($urandom), 1'b1, $urandom, $urandom);
            flush = (cyc == flush_at);
            #1;
            if (bus.o_btb_we) begin
                btb_n++;
                if (int'(bus.o_btb_waddr) != e || bus.o_btb_wdata != '0) bad++;
            end else bad++;
            if (bus.o_pht_we) begin
                pht_n++;
                if (e >= PHT_N || int'(bus.o_pht_waddr) != e || bus.o_pht_wdata != 2'd0) bad++;
            end else if (e < PHT_N) bad++;
            if (ghr_clr) begin
                ghr_n++;
                if (e != 0) bad++;
            end
            if (pred_en || (upd_dropped != v)) bad++;
            if (clr_done) begin
                done_n++;
                done_cyc = cyc;
                fin = 1'b1;
            end
            e = flush ? 0 : e + 1;
            cyc++;
            @(negedge clk);
        end
        flush = 1'b0;
        exp_btb  = (flush_at < 0) ? BTB_N : flush_at + 1 + BTB_N;
        exp_pht  = (flush_at < 0) ? PHT_N : (((flush_at + 1) < PHT_N) ? flush_at + 1 : PHT_N) + PHT_N;
        exp_ghr  = (flush_at < 0) ? 1 : 2;
        exp_done = (flush_at < 0) ? BTB_N - 1 : flush_at + BTB_N;
        chk({tag, "_btb_writes"}, btb_n, exp_btb);
        chk({tag, "_pht_writes"}, pht_n, exp_pht);
        chk({tag, "_ghr_pulses"}, ghr_n, exp_ghr);
        chk({tag, "_done_count"}, done_n, 1);
        chk({tag, "_done_cycle"}, done_cyc, exp_done);
        chk({tag, "_bad_cycles"}, bad, 0);
        $display("sweep %s: %0d cycles, btb=%0d pht=%0d ghr=%0d done@%0d", tag, cyc, btb_n, pht_n, ghr_n, done_cyc);
        foreach (truth[i]) truth[i] = 0;
        pend_v = 1'b0;
        drive(0, 8'h00, 1'b0, 32'h0, 32'h0);
        #1;
        chk({tag, "_pred_en_after"}, pred_en, 1);
        chk({tag, "_ghr_after"}, ghr_clr, 0);
        check_pend();
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          v, tk;
        logic [7:0]  p;
        drive(0, 8'h00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        chk("rst_pred_en", pred_en, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_ghr_clr", ghr_clr, 1);
        chk("rst_btb_we", bus.o_btb_we, 1);
        chk("rst_btb_waddr", bus.o_btb_waddr, 0);
        chk("rst_pht_we", bus.o_pht_we, 1);
        chk("rst_dropped", upd_dropped, 0);
        @(negedge clk);
        rst = 1'b0;
        sweep("init", -1);

        // Single taken update, table returns 1.
        rd_force_en = 1'b1;
        rd_force_val = 2'd1;
        run_cycle(1, 8'h12, 1, 32'hABCD_1234, 32'h8000_0F08, 2);
        rd_force_val = 2'd0;
        run_cycle(0, 8'h00, 0, 32'h0, 32'h0, -1);

        // Back-to-back taken on one pattern with a stale table read.
        run_cycle(1, 8'h05, 1, 32'h0000_1000, 32'h0000_2000, 1);
        run_cycle(1, 8'h05, 1, 32'h0000_1004, 32'h0000_2004, 2);
        run_cycle(1, 8'h05, 1, 32'h0000_1008, 32'h0000_2008, 3);
        run_cycle(1, 8'h05, 1, 32'h0000_100C, 32'h0000_200C, 3);
        run_cycle(0, 8'h00, 0, 32'h0, 32'h0, -1);

        // Not taken at the floor: PHT write 0, no BTB write.
        run_cycle(1, 8'h33, 0, 32'h1234_5678, 32'h0, 0);
        run_cycle(0, 8'h00, 0, 32'h0, 32'h0, -1);

        // Flush while S2 holds a write: write completes, DRAIN, then sweep.
        run_cycle(1, 8'h44, 1, 32'hCAFE_0010, 32'hBEEF_0020, 1);
        drive(1, 8'h55, 1, 32'h1, 32'h2);
        flush = 1'b1;
        #1;
        check_pend();
        chk("flush_drop", upd_dropped, 1);
        chk("flush_pred_en", pred_en, 1);
        pend_v = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        drive(1, 8'h56, 1, 32'h3, 32'h4);
        #1;
        check_pend();
        chk("drain_pred_en", pred_en, 0);
        chk("drain_dropped", upd_dropped, 1);
        chk("drain_ghr", ghr_clr, 0);
        @(negedge clk);
        sweep("after_drain", -1);

        // Randomized updates against the table-level model.
        rd_force_en = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            p  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
            tk = $urandom_range(0, 1) == 1;
            run_cycle(v, p, tk, $urandom, $urandom, -1);
        end
        run_cycle(0, 8'h00, 0, 32'h0, 32'h0, -1);

        // Flush from RUN with empty S2 goes straight to CLEAR; then abort at 500.
        drive(1, 8'h01, 1, 32'h5, 32'h6);
        flush = 1'b1;
        #1;
        chk("run_flush_drop", upd_dropped, 1);
        check_pend();
        @(negedge clk);
        sweep("flush500", 500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
